// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        dhit;
   logic [31:0] dmemload;
   logic        dmem_err;
   logic        busy;
   logic [31:0] access_cnt;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload, dmem_err, busy, access_cnt
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload, dmem_err, busy, access_cnt
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: samples a request in IDLE and waits WAIT_STATES cycles.
// It then strobes dhit for one cycle and serves the access from a local word store.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   dmem_responder_if.slave  dif
);
   localparam int          AW    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, HIT} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     data_q, data_d;
   logic            wr_q, wr_d;
   logic            err_q, err_d;
   logic            dhit_q, dhit_d;
   logic            derr_q, derr_d;
   logic            busy_q, busy_d;
   logic [31:0]     load_q, load_d;
   logic [31:0]     acc_q, acc_d;
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            req, in_err, enter_hit, we;
   logic [AW-1:0]   h_idx;
   logic [31:0]     h_data;
   logic            h_wr, h_err;

   assign req    = dif.dmemREN | dif.dmemWEN;
   assign in_err = (dif.dmemaddr[1:0] != 2'b00) || (dif.dmemaddr >= LIMIT) ||
                   (dif.dmemREN && dif.dmemWEN);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_d    = data_q;
      wr_d      = wr_q;
      err_d     = err_q;
      enter_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               idx_d  = dif.dmemaddr[2 +: AW];
               data_d = dif.dmemstore;
               wr_d   = dif.dmemWEN;
               err_d  = in_err;
               cnt_d  = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d   = HIT;
                  enter_hit = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d   = HIT;
                  enter_hit = 1'b1;
               end
            end
         end
         HIT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With zero wait states the access completes on the sampling edge, so use the live inputs.
   always_comb begin
      h_idx  = idx_q;
      h_data = data_q;
      h_wr   = wr_q;
      h_err  = err_q;
      if (state_q == IDLE) begin
         h_idx  = dif.dmemaddr[2 +: AW];
         h_data = dif.dmemstore;
         h_wr   = dif.dmemWEN;
         h_err  = in_err;
      end
      we     = enter_hit && h_wr && !h_err;
      dhit_d = enter_hit;
      derr_d = enter_hit && h_err;
      busy_d = (state_d != IDLE);
      load_d = (enter_hit && !h_wr && !h_err) ? mem_q[h_idx] : 32'd0;
      acc_d  = acc_q;
      if (state_q == HIT && !derr_q && acc_q != 32'hFFFF_FFFF)
         acc_d = acc_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         dhit_q  <= 1'b0;
         derr_q  <= 1'b0;
         busy_q  <= 1'b0;
         load_q  <= '0;
         acc_q   <= '0;
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         dhit_q  <= dhit_d;
         derr_q  <= derr_d;
         busy_q  <= busy_d;
         load_q  <= load_d;
         acc_q   <= acc_d;
         if (we) mem_q[h_idx] <= h_data;
      end
   end

   assign dif.dhit       = dhit_q;
   assign dif.dmemload   = load_q;
   assign dif.dmem_err   = derr_q;
   assign dif.busy       = busy_q;
   assign dif.access_cnt = acc_q;
endmodule
